// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_pkg : shared constants and FSM encoding for the sequential divider   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package div_pkg;

    localparam int DIV_WIDTH = 64;

    localparam logic [DIV_WIDTH-1:0] ALL_ONES = {DIV_WIDTH{1'b1}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/div_step_64.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_step_64 : one restoring-division step (shift in q_msb, trial subtract)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_step_64
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] next_rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] w_rem_shift;
    logic [WIDTH:0] w_low;

    assign w_rem_shift = {rem_i, q_msb_i};
    assign w_low       = {1'b0, w_rem_shift[WIDTH-1:0]} - {1'b0, divisor_i};

    // A set extension bit absorbs any borrow out of the 64-bit subtractor.
    assign q_bit_o    = w_rem_shift[WIDTH] | ~w_low[WIDTH];
    assign next_rem_o = q_bit_o ? w_low[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/div_seq_64.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_seq_64 : multi-cycle signed/unsigned restoring divider, 1 bit/cycle   |
// | Optional macro DIV_SHORTCUT_EN: skip iteration when |dividend|<|divisor| |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_seq_64
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             signed_q, signed_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic             short_q, short_d;

    logic             w_dvd_neg, w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
    logic [WIDTH-1:0] w_step_rem, w_step_dvs, w_next_rem;
    logic             w_step_msb, w_q_bit;

    assign w_dvd_neg = signed_q & dvd_q[WIDTH-1];
    assign w_dvs_neg = signed_q & dvs_q[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dvd_q : dvd_q;
    assign w_dvs_mag = w_dvs_neg ? -dvs_q : dvs_q;

    // The step is idle in PREP; there it compares |dividend| against |divisor|.
    always_comb begin
        if (state_q == S_PREP) begin
            w_step_rem = {1'b0, w_dvd_mag[WIDTH-1:1]};
            w_step_msb = w_dvd_mag[0];
            w_step_dvs = w_dvs_mag;
        end else begin
            w_step_rem = rem_q;
            w_step_msb = dvd_q[WIDTH-1];
            w_step_dvs = dvs_q;
        end
    end

    div_step_64 #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i      (w_step_rem),
        .q_msb_i    (w_step_msb),
        .divisor_i  (w_step_dvs),
        .next_rem_o (w_next_rem),
        .q_bit_o    (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = (dvs_q == '0) ? S_FIX : S_ITER;
            S_ITER:  if (short_q || (cnt_q == CNT_W'(WIDTH - 1))) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready       = (state_q == S_IDLE);
        done        = (state_q == S_DONE);
        quotient    = quot_q;
        remainder   = remo_q;
        div_by_zero = dbz_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        remo_d     = remo_q;
        signed_d   = signed_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        short_d    = short_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d    = dividend;
                    dvs_d    = divisor;
                    signed_d = signed_op;
                    dbz_d    = 1'b0;
                end
            end
            S_PREP: begin
                cnt_d      = '0;
                rem_d      = '0;
                short_d    = 1'b0;
                neg_quot_d = w_dvd_neg ^ w_dvs_neg;
                neg_rem_d  = w_dvd_neg;
                dvd_d      = w_dvd_mag;
                dvs_d      = w_dvs_mag;
                if (dvs_q == '0) begin
                    // FIX passes these through untouched because both signs are cleared.
                    dvd_d      = WIDTH'(ALL_ONES);
                    rem_d      = dvd_q;
                    neg_quot_d = 1'b0;
                    neg_rem_d  = 1'b0;
                    dbz_d      = 1'b1;
                end
`ifdef DIV_SHORTCUT_EN
                else if (!w_q_bit) begin
                    dvd_d   = '0;
                    rem_d   = w_dvd_mag;
                    short_d = 1'b1;
                end
`endif
            end
            S_ITER: begin
                if (!short_q) begin
                    rem_d = w_next_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], w_q_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                quot_d = neg_quot_q ? -dvd_q : dvd_q;
                remo_d = neg_rem_q ? -rem_q : rem_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            remo_q     <= '0;
            signed_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            signed_q   <= signed_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            short_q    <= short_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_64.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_seq_64 : directed scoreboard bench for div_seq_64                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_div_seq_64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        ready, done, div_by_zero;
    logic [63:0] quotient, remainder;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        int unsigned at;
        string       name;
    } exp_t;

    exp_t sb[$];

    div_seq_64 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " quotient"}, quotient, e.q);
                    chk({e.name, " remainder"}, remainder, e.r);
                    chk({e.name, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
                    chk({e.name, " done_cycle"}, 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    // Called at a negedge; returns the accept edge number k.
    task automatic issue(input string name, input logic sop, input logic [63:0] a, input logic [63:0] b,
                         input bit expect_done, input logic [63:0] eq, input logic [63:0] er,
                         input logic edbz, input int unsigned lat, output int unsigned k);
        exp_t e;
        int guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) fail_now({name, " ready_wait"});
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        k = cyc + 1;
        if (expect_done) begin
            e.q = eq; e.r = er; e.dbz = edbz; e.at = k + lat; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = 64'hDEAD_BEEF_0BAD_F00D;
        divisor  = 64'h0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((sb.size() != 0 || ready !== 1'b1) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || ready !== 1'b1) fail_now({name, " drain"});
    endtask

    task automatic wait_cycle(input int unsigned target);
        int guard = 0;
        while (cyc < target && guard < 300) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run(input string name, input logic sop, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er, input logic edbz, input int unsigned lat);
        int unsigned k;
        issue(name, sop, a, b, 1'b1, eq, er, edbz, lat, k);
        drain(name);
    endtask

    initial begin
        int unsigned k;
        int unsigned short_lat;
`ifdef DIV_SHORTCUT_EN
        short_lat = 3;
`else
        short_lat = 66;
`endif
        repeat (3) @(negedge clk);
        chk("reset ready", {63'd0, ready}, 64'd1);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset quotient", quotient, 64'd0);
        chk("reset remainder", remainder, 64'd0);
        chk("reset dbz", {63'd0, div_by_zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("u100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 66);
        run("s-7/2", 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
        run("s7/-2", 1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 66);
        run("s-100/-7", 1'b1, -64'sd100, -64'sd7, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        run("u0x1234/0", 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 2);
        run("s0x1234/0", 1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 2);
        run("sMIN/-1", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 64'd0, 1'b0, 66);
        run("uMAX/1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 66);

        // Start while busy must be dropped without disturbing the running op.
        issue("busy100/7", 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 1'b0, 66, k);
        wait_cycle(k + 9);
        chk("busy ready", {63'd0, ready}, 64'd0);
        signed_op = 1'b0;
        dividend  = 64'd5;
        divisor   = 64'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("busy100/7");
        run("u9/3", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 66);

        // Asynchronous reset in the middle of iteration aborts silently.
        issue("abort", 1'b0, 64'd100, 64'd7, 1'b0, 64'd0, 64'd0, 1'b0, 0, k);
        wait_cycle(k + 30);
        rst_n = 1'b0;
        #1;
        chk("abort ready", {63'd0, ready}, 64'd1);
        chk("abort done", {63'd0, done}, 64'd0);
        chk("abort quotient", quotient, 64'd0);
        chk("abort remainder", remainder, 64'd0);
        chk("abort dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("post100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 66);
        run("u3/10", 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, 1'b0, short_lat);

        repeat (80) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
